usb_packet_buffer: RTL and testbench

Parametrised byte-granular packet buffer between the AHB-Lite slave (word side) and the USB RX/TX engines (byte side). It is the next-generation data buffer: depth and host word width are parameters, host transfers of 1..WORD_BYTES bytes are packed in one cycle, and it adds full/empty flags, sticky overflow/underflow errors, lock enforcement and defined arbitration for simultaneous accesses. It sits under the protocol controller, which drives `clear` and `lock_db`.

---
 rtl/usb_buffer_pkg.sv | 20 ++
 rtl/buffer_byte_mem.sv | 35 +++
 rtl/usb_packet_buffer.sv | 139 +++++++++++++
 tb/tb_usb_packet_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buffer_pkg.sv
// Shared definitions for the USB packet buffer: transfer-size encodings and the
// helper that converts a size code into a byte count.
package usb_buffer_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_3B   = 2'd2,
    SIZE_WORD = 2'd3
  } data_size_e;

  // Bytes moved by a host transfer: encoding + 1, never more than the word width.
  function automatic int unsigned size_to_bytes(input logic [1:0]  data_size,
                                                input int unsigned word_bytes);
    int unsigned n;
    n = 32'(data_size) + 32'd1;
    return (n > word_bytes) ? word_bytes : n;
  endfunction

endpackage

// File: rtl/buffer_byte_mem.sv
// Byte-wide circular storage with WORD_BYTES write lanes and WORD_BYTES read
// lanes. Lane i addresses base + i modulo DEPTH, so a word access may wrap.
module buffer_byte_mem #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned WORD_BYTES = 4,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [WORD_BYTES-1:0]   wr_en_i,
  input  logic [8*WORD_BYTES-1:0] wr_data_i,
  input  logic [AW-1:0]           rd_addr_i,
  output logic [8*WORD_BYTES-1:0] rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  // Write every enabled lane; lanes never alias because WORD_BYTES <= DEPTH.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (wr_en_i[i]) begin
        mem_q[wr_addr_i + AW'(i)] <= wr_data_i[8*i +: 8];
      end
    end
  end

  // Combinational read of WORD_BYTES consecutive bytes from the read base.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      rd_data_o[8*i +: 8] = mem_q[rd_addr_i + AW'(i)];
    end
  end

endmodule

// File: rtl/usb_packet_buffer.sv
// Byte-granular packet buffer between the host word interface and the USB byte
// engines. Holds pointers, occupancy, arbitration, lock handling and errors.
module usb_packet_buffer
  import usb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned WORD_BYTES = 4,
  localparam int unsigned OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    lock_db,
  input  logic                    store_tx_data,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  input  logic [1:0]              data_size,
  input  logic                    get_rx_data,
  output logic [8*WORD_BYTES-1:0] rx_data,
  input  logic                    store_rx_packet_data,
  input  logic [7:0]              rx_packet_data,
  input  logic                    get_tx_packet_data,
  output logic [7:0]              tx_packet_data,
  output logic [OCC_W-1:0]        buffer_occupancy,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow_err,
  output logic                    underflow_err,
  output logic                    lock_error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] DepthOcc = OCC_W'(DEPTH);

  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    ovf_q, ovf_d, udf_q, udf_d, lock_err_q, lock_err_d;

  logic [OCC_W-1:0]        host_n, push_n, pop_n, space;
  logic                    host_req, host_conflict;
  logic                    push_req, pop_req, push_ok, pop_ok;
  logic [WORD_BYTES-1:0]   wr_en;
  logic [8*WORD_BYTES-1:0] wr_data, rd_data;

  buffer_byte_mem #(
    .DEPTH      (DEPTH),
    .WORD_BYTES (WORD_BYTES)
  ) u_mem (
    .clk_i     (clk),
    .wr_addr_i (wr_ptr_q),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Arbitration (USB side wins), capacity checks against start-of-cycle occupancy.
  always_comb begin
    host_n        = OCC_W'(size_to_bytes(data_size, WORD_BYTES));
    space         = DepthOcc - occ_q;
    host_req      = store_tx_data || get_rx_data;
    host_conflict = (store_tx_data && store_rx_packet_data) ||
                    (get_rx_data && get_tx_packet_data);

    push_req = store_rx_packet_data || (store_tx_data && !lock_db);
    push_n   = store_rx_packet_data ? OCC_W'(1) : host_n;
    pop_req  = get_tx_packet_data || (get_rx_data && !lock_db);
    pop_n    = get_tx_packet_data ? OCC_W'(1) : host_n;

    push_ok = !clear && push_req && (push_n <= space);
    pop_ok  = !clear && pop_req && (pop_n <= occ_q);

    wr_data = tx_data;
    if (store_rx_packet_data) begin
      wr_data      = '0;
      wr_data[7:0] = rx_packet_data;
    end
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      wr_en[i] = push_ok && (OCC_W'(i) < push_n);
    end

    // A lock refusal is reported even while clearing; a lost arbitration is not.
    lock_err_d = host_req && (lock_db || (!clear && host_conflict));

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(push_n);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(pop_n);
      occ_d = occ_q + (push_ok ? push_n : '0) - (pop_ok ? pop_n : '0);
      if (push_req && !push_ok) ovf_d = 1'b1;
      if (pop_req && !pop_ok)   udf_d = 1'b1;
    end
  end

  // State registers; reset discards contents by zeroing pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Head views: bytes beyond the current occupancy read as zero.
  always_comb begin
    rx_data = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (OCC_W'(i) < occ_q) rx_data[8*i +: 8] = rd_data[8*i +: 8];
    end
    tx_packet_data = (occ_q != '0) ? rd_data[7:0] : 8'h00;
  end

  assign buffer_occupancy = occ_q;
  assign empty            = (occ_q == '0);
  assign full             = (occ_q == DepthOcc);
  assign overflow_err     = ovf_q;
  assign underflow_err    = udf_q;
  assign lock_error       = lock_err_q;

endmodule

// File: tb/tb_usb_packet_buffer.sv
// Scoreboard bench for usb_packet_buffer: the driver applies one cycle of
// requests at each falling edge and queues what the outputs should show in that
// cycle; a monitor pops and compares mid-low-phase. The reference is a byte queue.
module tb_usb_packet_buffer;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WB    = 4;
  localparam int unsigned OCC_W = 7;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              clear = 1'b0, lock_db = 1'b0;
  logic              store_tx_data = 1'b0, get_rx_data = 1'b0;
  logic              store_rx_packet_data = 1'b0, get_tx_packet_data = 1'b0;
  logic [8*WB-1:0]   tx_data = '0;
  logic [1:0]        data_size = '0;
  logic [7:0]        rx_packet_data = '0;
  logic [8*WB-1:0]   rx_data;
  logic [7:0]        tx_packet_data;
  logic [OCC_W-1:0]  buffer_occupancy;
  logic              empty, full, overflow_err, underflow_err, lock_error;

  usb_packet_buffer #(
    .DEPTH      (DEPTH),
    .WORD_BYTES (WB)
  ) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .lock_db              (lock_db),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .data_size            (data_size),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .empty                (empty),
    .full                 (full),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err),
    .lock_error           (lock_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OCC_W-1:0] occ;
    logic             empty, full, ovf, udf, lerr;
    logic [7:0]       txp;
    logic [31:0]      rxd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  bit         m_ovf, m_udf, m_lerr;
  int         tests = 0;
  int         fails = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endfunction

  // What the outputs should show given the reference contents and flags.
  function automatic exp_t snap();
    exp_t e;
    e.occ   = OCC_W'(mq.size());
    e.empty = (mq.size() == 0);
    e.full  = (mq.size() == DEPTH);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    e.lerr  = m_lerr;
    e.txp   = (mq.size() > 0) ? mq[0] : 8'h00;
    e.rxd   = '0;
    for (int i = 0; i < int'(WB); i++) begin
      if (i < mq.size()) e.rxd[8*i +: 8] = mq[i];
    end
    return e;
  endfunction

  // One clock cycle of stimulus plus the reference model's view of it.
  task automatic cyc(input bit rst, input bit clr, input bit lck, input bit stx,
                     input logic [31:0] txd, input logic [1:0] ds, input bit grx,
                     input bit srx, input logic [7:0] rxb, input bit gtx);
    int c, n;
    @(negedge clk);
    n_rst                = !rst;
    clear                = rst ? 1'b0 : clr;
    lock_db              = rst ? 1'b0 : lck;
    store_tx_data        = rst ? 1'b0 : stx;
    tx_data              = txd;
    data_size            = ds;
    get_rx_data          = rst ? 1'b0 : grx;
    store_rx_packet_data = rst ? 1'b0 : srx;
    rx_packet_data       = rxb;
    get_tx_packet_data   = rst ? 1'b0 : gtx;
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_lerr = 1'b0;
      exp_q.push_back(snap());
      return;
    end
    exp_q.push_back(snap());
    n = int'(ds) + 1;
    if (n > int'(WB)) n = int'(WB);
    m_lerr = (stx || grx) && (lck || (!clr && ((stx && srx) || (grx && gtx))));
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      c = mq.size();
      if (gtx) begin
        if (c >= 1) void'(mq.pop_front());
        else m_udf = 1'b1;
      end else if (grx && !lck) begin
        if (c >= n) repeat (n) void'(mq.pop_front());
        else m_udf = 1'b1;
      end
      if (srx) begin
        if (c + 1 <= int'(DEPTH)) mq.push_back(rxb);
        else m_ovf = 1'b1;
      end else if (stx && !lck) begin
        if (c + n <= int'(DEPTH)) begin
          for (int i = 0; i < n; i++) mq.push_back(txd[8*i +: 8]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();                  cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic usb_push(input logic [7:0] b); cyc(0, 0, 0, 0, 0, 0, 0, 1, b, 0); endtask
  task automatic usb_pop();               cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic host_push(input logic [31:0] d, input logic [1:0] ds);
    cyc(0, 0, 0, 1, d, ds, 0, 0, 0, 0);
  endtask
  task automatic host_pop(input logic [1:0] ds); cyc(0, 0, 0, 0, 0, ds, 1, 0, 0, 0); endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("occupancy", 32'(buffer_occupancy), 32'(e.occ));
        chk("empty", 32'(empty), 32'(e.empty));
        chk("full", 32'(full), 32'(e.full));
        chk("overflow_err", 32'(overflow_err), 32'(e.ovf));
        chk("underflow_err", 32'(underflow_err), 32'(e.udf));
        chk("lock_error", 32'(lock_error), 32'(e.lerr));
        chk("tx_packet_data", 32'(tx_packet_data), 32'(e.txp));
        chk("rx_data", rx_data, e.rxd);
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Word push then byte-wise drain.
    host_push(32'hDDCC_BBAA, 2'd3);
    repeat (4) usb_pop();
    idle();

    // Fill to full, refused host push, clear.
    for (int i = 0; i < int'(DEPTH); i++) usb_push(8'(i + 8'h40));
    host_push(32'h1234_5678, 2'd0);
    idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Walk pointers to 62, then a word write that wraps.
    for (int i = 0; i < 62; i++) usb_push(8'(i));
    for (int i = 0; i < 62; i++) usb_pop();
    host_push(32'h4433_2211, 2'd3);
    repeat (4) usb_pop();

    // Underflow on a short host pop with partial head visible.
    usb_push(8'hA1);
    usb_push(8'hB2);
    host_pop(2'd3);
    idle();

    // Locked host push alongside an accepted USB push.
    cyc(0, 0, 1, 1, 32'hCAFE_F00D, 2'd3, 0, 1, 8'hC3, 0);
    idle();

    // Reach occupancy 10, then host and USB push collide.
    for (int i = 0; i < 7; i++) usb_push(8'(8'h70 + i));
    cyc(0, 0, 0, 1, 32'h0000_5566, 2'd1, 0, 1, 8'hE7, 0);
    idle();
    host_pop(2'd3);
    host_pop(2'd1);

    // Reset mid-stream, then resume.
    host_push(32'h0BAD_BEEF, 2'd3);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Randomized traffic with an occasional reset.
    for (int k = 0; k < 1500; k++) begin
      if (k == 750) begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        cyc(0, $urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 8'($urandom),
            $urandom_range(0, 2) == 0);
      end
    end
    idle();
    idle();

    @(negedge clk);
    #4;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
